// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings,
// default timing constants for the 50 MHz board and a small helper.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } key_state_e;

    // Defaults for a 50 MHz clock: 100 Hz sample, 500 ms hold, 100 ms repeat.
    localparam int unsigned SAMPLE_DIV_DEF = 500000;
    localparam int unsigned DB_CNT_DEF     = 3;
    localparam int unsigned HOLD_TICKS_DEF = 50;
    localparam int unsigned RPT_TICKS_DEF  = 10;

    localparam int unsigned TICK_W = 32;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_tick.sv
// Sample-tick divider: a 32-bit counter running 0..SAMPLE_DIV-1 that flags
// the last count as a one-clk tick.
module key_tick
    import key_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(SAMPLE_DIV - 1);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    // Tick on the terminal count, wrap to zero after it.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + TICK_W'(1);
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_cond.sv
// Push-button conditioner: synchronises an active-low switch, debounces it on
// a slow sample tick and emits a one-clk press pulse per accepted press.
// Build option KEY_COND_RPT_EN adds auto-repeat pulses while the key is held
// and drives o_hold during the repeat phase; without it o_hold is tied low.
module key_cond
    import key_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int unsigned DB_CNT     = DB_CNT_DEF,
    parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF,
    parameter int unsigned RPT_TICKS  = RPT_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_level,
    output logic o_press,
    output logic o_hold
);

    localparam int unsigned DB_W = (DB_CNT > 1) ? $clog2(DB_CNT + 1) : 1;

    if (SAMPLE_DIV == 0 || DB_CNT == 0 || HOLD_TICKS == 0 || RPT_TICKS == 0) begin : g_cfg_check
        $error("key_cond: all timing parameters must be non-zero");
    end

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic sw_s;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_sw;
            sync2_q <= sync1_q;
        end
    end

    assign sw_s = ~sync2_q;

    // ------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------
    logic tick;

    key_tick #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;

    // Count consecutive differing samples; flip the level on the DB_CNT-th.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (tick) begin
            if (sw_s != level_q) begin
                if (db_cnt_q == DB_W'(DB_CNT - 1)) begin
                    level_d  = ~level_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    // Debounce counter and debounced level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Press / repeat FSM
    // ------------------------------------------------------------------
    key_state_e state_q, state_d;
    logic       press_q, press_d;

`ifdef KEY_COND_RPT_EN
    localparam int unsigned HC_MAX = max_u(HOLD_TICKS, RPT_TICKS);
    localparam int unsigned HC_W   = (HC_MAX > 1) ? $clog2(HC_MAX + 1) : 1;

    logic [HC_W-1:0] hc_q, hc_d;
    logic [HC_W-1:0] hc_inc, hc_lim;
    logic            hold_q, hold_d;
    logic            level_fall;

    // A fall decided this cycle must veto a repeat landing on the same tick.
    assign level_fall = level_q & ~level_d;

    // Next state: press on rise, count hold ticks, repeat while held.
    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        hold_d  = hold_q;
        hc_d    = hc_q;
        hc_inc  = hc_q + HC_W'(1);
        hc_lim  = (state_q == ST_RPT) ? HC_W'(RPT_TICKS) : HC_W'(HOLD_TICKS);
        unique case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    press_d = 1'b1;
                    hc_d    = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT, ST_RPT: begin
                if (!level_q) begin
                    hold_d  = 1'b0;
                    hc_d    = '0;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (hc_inc == hc_lim) begin
                        hc_d = '0;
                        if (!level_fall) begin
                            press_d = 1'b1;
                            hold_d  = 1'b1;
                            state_d = ST_RPT;
                        end
                    end else begin
                        hc_d = hc_inc;
                    end
                end
            end
            default: begin
                hold_d  = 1'b0;
                hc_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hold counter and repeat-phase flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q   <= '0;
            hold_q <= 1'b0;
        end else begin
            hc_q   <= hc_d;
            hold_q <= hold_d;
        end
    end

    assign o_hold = hold_q;
`else
    // Next state: one press on rise, then wait for release.
    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    press_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_hold = 1'b0;
`endif

    // FSM state and press pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
        end
    end

    assign o_level = level_q;
    assign o_press = press_q;

endmodule

// File: tb/tb_key_cond.sv
// Self-checking bench for key_cond: per-cycle comparison against a tick-level
// behavioural model, a table of press durations, and hand-written sequences
// for reset, bounce and reset-during-press.
module tb_key_cond;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int HT = 5;
    localparam int RT = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic i_sw = 1'b1;
    logic o_level, o_press, o_hold;

    key_cond #(
        .SAMPLE_DIV(SD),
        .DB_CNT    (DB),
        .HOLD_TICKS(HT),
        .RPT_TICKS (RT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_sw   (i_sw),
        .o_level(o_level),
        .o_press(o_press),
        .o_hold (o_hold)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: ticks from a cycle count, debounce by sample
    // counting, repeats from the number of ticks held since the press.
    // ------------------------------------------------------------------
    int m_div = 0;
    int m_dbc = 0;
    int m_t   = 0;
    bit m_s1 = 1'b1, m_s2 = 1'b1;
    bit m_level = 1'b0, m_press = 1'b0, m_hold = 1'b0, m_active = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div = 0; m_dbc = 0; m_t = 0;
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_level = 1'b0; m_press = 1'b0; m_hold = 1'b0; m_active = 1'b0;
        end else begin
            bit tk;
            bit lvl_n;
            tk    = (m_div == SD - 1);
            lvl_n = m_level;
            if (tk) begin
                if ((!m_s2) != m_level) begin
                    m_dbc++;
                    if (m_dbc == DB) begin
                        lvl_n = !m_level;
                        m_dbc = 0;
                    end
                end else begin
                    m_dbc = 0;
                end
            end
            m_press = 1'b0;
            if (!m_active) begin
                if (m_level) begin
                    m_press  = 1'b1;
                    m_active = 1'b1;
                    m_t      = 0;
                end
            end else if (!m_level) begin
                m_active = 1'b0;
                m_hold   = 1'b0;
            end else if (tk) begin
                m_t++;
`ifdef KEY_COND_RPT_EN
                if (m_t >= HT && ((m_t - HT) % RT) == 0 && lvl_n) begin
                    m_press = 1'b1;
                    m_hold  = 1'b1;
                end
`endif
            end
            m_div   = tk ? 0 : m_div + 1;
            m_s2    = m_s1;
            m_s1    = i_sw;
            m_level = lvl_n;
        end
    end

    // Per-cycle comparison plus running activity counters.
    int  pulse_total = 0;
    int  hold_total  = 0;
    int  wide_total  = 0;
    logic prev_press = 1'b0;

    always @(negedge clk) begin
        check("cycle_outputs", {29'd0, o_level, o_press, o_hold},
              {29'd0, m_level, m_press, m_hold});
        if (o_press === 1'b1) pulse_total++;
        if (o_hold === 1'b1) hold_total++;
        if (o_press === 1'b1 && prev_press === 1'b1) wide_total++;
        prev_press = o_press;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Wait for o_level to reach val; returns cycles taken, or -1 on timeout.
    task automatic wait_level(input logic val, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (o_level === val) begin
                n = k;
                break;
            end
        end
    endtask

    typedef struct {
        int h;
        int exp_pulses;
        bit exp_hold_seen;
        bit exp_hold_at_fall;
    } vec_t;

    vec_t vecs[6];

    // Press, hold raw switch for h ticks after o_level rises, release.
    task automatic do_press(input vec_t v);
        int p0, h0, n;
        p0 = pulse_total;
        h0 = hold_total;
        i_sw = 1'b0;
        wait_level(1'b1, 40, n);
        check("press_level_rise", (n > 0), 1);
        repeat (4 * v.h) step();
        i_sw = 1'b1;
        wait_level(1'b0, 60, n);
        check("release_level_fall", (n > 0), 1);
        check("hold_at_fall", o_hold, v.exp_hold_at_fall);
        step();
        check("hold_after_fall", o_hold, 0);
        repeat (10) step();
        check("press_pulses", pulse_total - p0, v.exp_pulses);
        check("hold_seen", (hold_total - h0) > 0, v.exp_hold_seen);
    endtask

    initial begin
        int n, bad, p0, len;

`ifdef KEY_COND_RPT_EN
        vecs[0] = '{1, 1, 1'b0, 1'b0};
        vecs[1] = '{2, 1, 1'b0, 1'b0};   // release lands on the first repeat tick
        vecs[2] = '{3, 2, 1'b1, 1'b1};
        vecs[3] = '{4, 2, 1'b1, 1'b1};   // release lands on a repeat tick in RPT
        vecs[4] = '{12, 6, 1'b1, 1'b1};
        vecs[5] = '{15, 8, 1'b1, 1'b1};
`else
        vecs[0] = '{1, 1, 1'b0, 1'b0};
        vecs[1] = '{2, 1, 1'b0, 1'b0};
        vecs[2] = '{3, 1, 1'b0, 1'b0};
        vecs[3] = '{4, 1, 1'b0, 1'b0};
        vecs[4] = '{12, 1, 1'b0, 1'b0};
        vecs[5] = '{15, 1, 1'b0, 1'b0};
`endif

        // Reset with the key pressed.
        i_sw = 1'b0;
        rst  = 1'b1;
        repeat (5) step();
        check("rst_level", o_level, 0);
        check("rst_press", o_press, 0);
        check("rst_hold", o_hold, 0);
        rst = 1'b0;
        wait_level(1'b1, 40, n);
        check("rst_release_latency", (n >= DB * SD && n <= (DB + 1) * SD + 2), 1);
        i_sw = 1'b1;
        wait_level(1'b0, 60, n);
        check("rst_release_fall", (n > 0), 1);
        repeat (10) step();

        // Bounce: toggle every 5 clk for 60 clk, then hold pressed.
        bad = 0;
        p0  = pulse_total;
        for (int k = 0; k < 12; k++) begin
            i_sw = ~i_sw;
            repeat (5) begin
                step();
                if (o_level !== 1'b0 || o_press !== 1'b0) bad++;
            end
        end
        check("bounce_quiet", bad, 0);
        i_sw = 1'b0;
        wait_level(1'b1, 40, n);
        check("bounce_level_rise", (n > 0), 1);
        repeat (3) step();
        check("bounce_one_press", pulse_total - p0, 1);
        i_sw = 1'b1;
        wait_level(1'b0, 60, n);
        repeat (10) step();

        // Table of hold durations.
        for (int i = 0; i < 6; i++) begin
            do_press(vecs[i]);
        end

        // Reset asserted while the key is held in the repeat phase.
        i_sw = 1'b0;
        wait_level(1'b1, 40, n);
        repeat (30) step();
        rst = 1'b1;
        step();
        check("midrst_level", o_level, 0);
        check("midrst_press", o_press, 0);
        check("midrst_hold", o_hold, 0);
        repeat (3) step();
        rst = 1'b0;
        wait_level(1'b1, 40, n);
        check("midrst_full_debounce", (n >= DB * SD), 1);
        i_sw = 1'b1;
        wait_level(1'b0, 60, n);
        repeat (10) step();

        // Random switch activity with occasional resets.
        for (int s = 0; s < 150; s++) begin
            i_sw = 1'($urandom_range(0, 1));
            len  = int'($urandom_range(1, 120));
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            repeat (len) step();
        end
        i_sw = 1'b1;
        repeat (60) step();

        check("press_width_1clk", wide_total, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_cond.md
# key_cond

Push-button conditioner placed between the board switch pins and the clock controller's mode, position and increment inputs. It does three things:
- synchronises a raw active-low switch;
- debounces it on a slow sample tick;
- emits a one-`clk` press pulse, plus auto-repeat pulses while the key is held, so setup mode can step quickly through seconds, minutes and hours.

One instance is used per switch.

## Interface
Parameters:
- `SAMPLE_DIV`, default 500000: `clk` cycles per debounce sample tick (100 Hz at 50 MHz).
- `DB_CNT`, default 3: consecutive equal samples required to change the debounced level.
- `HOLD_TICKS`, default 50: ticks the key must be held before the first repeat (500 ms).
- `RPT_TICKS`, default 10: ticks between repeat pulses (100 ms).

Ports:
- `clk`, input, 1: system clock, 50 MHz. This is the only clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `i_sw`, input, 1: raw switch. 0 means pressed. Asynchronous to `clk`.
- `o_level`, output, 1: debounced level. 1 means pressed.
- `o_press`, output, 1: single-`clk` pulse on each accepted press and on each repeat.
- `o_hold`, output, 1: high while the block is in the repeat phase.

## Operation
Reset values:
- Sync flops: 1 (released).
- `o_level`, `o_press`, `o_hold`: 0.
- Tick counter, debounce counter and hold counter: 0.
- FSM: `IDLE`.

Synchroniser:
- Two flops on `i_sw`, inverted to active-high as `sw_s`.

Sample tick:
- The tick counter counts 0 to `SAMPLE_DIV-1`, then wraps.
- `tick` is high for one `clk` when the counter is at `SAMPLE_DIV-1`.

Debounce:
- On each `tick`, compare `sw_s` with `o_level`.
- If they differ, increment the debounce counter. When the counter reaches `DB_CNT`, toggle `o_level` and clear the counter.
- If they are equal, clear the debounce counter.

FSM states and transitions:
- `IDLE`:
  - When `o_level` rises, pulse `o_press`, clear the hold counter, go to `WAIT`.
- `WAIT`:
  - On each `tick`, increment the hold counter.
  - When the counter reaches `HOLD_TICKS`, pulse `o_press`, set `o_hold`, clear the counter, go to `RPT`.
  - If `o_level` falls, go to `IDLE`.
- `RPT`:
  - On each `tick`, increment the hold counter.
  - When the counter reaches `RPT_TICKS`, pulse `o_press` and clear the counter.
  - If `o_level` falls, clear `o_hold` and go to `IDLE`.

Rules:
- Release has priority. If `o_level` falls in the same cycle that the hold counter reaches its limit, no pulse is emitted.
- Hold counter width is `$clog2(max(HOLD_TICKS, RPT_TICKS)+1)`. It never exceeds its limit.
- Tick counter is 32 bits.
- Asserting `rst` mid-press forces all reset values immediately. After release of `rst`, a still-held key produces a new press only after a full `DB_CNT` debounce.

## Timing
- `o_level` latency after a stable raw edge: 2 `clk` (sync) plus `DB_CNT` to `DB_CNT+1` ticks.
- `o_press` goes high exactly 1 `clk` after the `clk` in which `o_level` rises, and lasts exactly 1 `clk`.
- First repeat pulse: `HOLD_TICKS` ticks after the press pulse, within ±1 tick.
- Subsequent repeats: exactly `RPT_TICKS` ticks apart.
- `o_hold` rises in the same cycle as the first repeat pulse.
- `o_hold` falls 1 `clk` after `o_level` falls.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
Macro `KEY_COND_RPT_EN`:
- Defined: the full `WAIT`/`RPT` auto-repeat behaviour described above is built.
- Undefined:
  - The FSM reduces to `IDLE`/`WAIT`. `WAIT` only waits for release.
  - One `o_press` per accepted press.
  - `o_hold` is tied to 0.
  - The hold counter is not instantiated.
  - `HOLD_TICKS` and `RPT_TICKS` are ignored.

## Structure
Shared definitions file `key_pkg`:
- FSM state encodings `ST_IDLE`=2'd0, `ST_WAIT`=2'd1, `ST_RPT`=2'd2.
- Default constants for the 50 MHz board.

Sub-module `key_tick`:
- Parameterised divider producing the one-cycle `tick`.
- A single instance may be shared by all `key_cond` instances through an optional `tick` input in a later revision. For now it is instantiated per `key_cond`.

## Test plan
All scenarios use `SAMPLE_DIV`=4, `DB_CNT`=3, `HOLD_TICKS`=5, `RPT_TICKS`=2.
- Reset: hold `rst`=1 with `i_sw`=0 (pressed). Required: `o_level`, `o_press`, `o_hold` all 0; release `rst` -> `o_level` rises after 3 or 4 ticks.
- Bounce: `i_sw` toggling every 5 `clk` for 60 `clk`, then stable 0 (pressed). Required: exactly one `o_press` pulse, 1 `clk` wide, and no activity during the bounce.
- Short press: press held for 4 ticks after `o_level` rises, then released. Required: one `o_press`; `o_hold` stays 0; FSM back in `IDLE`.
- Auto-repeat: press held for 15 ticks after `o_level` rises. Required:
  - pulses at tick offsets 0, 5, 7, 9, 11, 13, 15;
  - `o_hold` high from offset 5 until 1 `clk` after `o_level` falls.
- Release coinciding with a repeat tick. Required: no pulse in that cycle; `o_hold` falls 1 `clk` after `o_level` falls.
- Build without `KEY_COND_RPT_EN`, same 15-tick hold. Required: a single pulse, and `o_hold` constantly 0.
